// File: rtl/branch_predictor_if.sv
// Fetch/update bus between the pipeline and the branch predictor.
// The master is the pipeline side: it presents the fetch PC and resolved
// branch outcomes. The slave is the predictor: it returns the prediction
// and the flush/recovery request.
interface branch_predictor_if;
    logic [31:0] fetch_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_taken;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        mispredict;
    logic [31:0] recover_pc;

    modport master (
        output fetch_pc, upd_valid, upd_pc, upd_target, upd_taken,
               upd_pred_taken, upd_pred_target,
        input  pred_taken, pred_target, mispredict, recover_pc
    );

    modport slave (
        input  fetch_pc, upd_valid, upd_pc, upd_target, upd_taken,
               upd_pred_taken, upd_pred_target,
        output pred_taken, pred_target, mispredict, recover_pc
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating counters.
// Lookup is combinational on fetch_pc; training happens on the clock edge
// from the resolved instruction in MEM. Valid bits and counters clear
// asynchronously on RST; tags and targets are left as they are because an
// invalid entry can never hit.
// Optional feature: define BRANCH_PREDICTOR_STATS_EN to add saturating
// lookup / mispredict statistics counters and their output ports.
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2
) (
    input  logic                CLK,
    input  logic                RST,
    branch_predictor_if.slave   bus
`ifdef BRANCH_PREDICTOR_STATS_EN
    ,
    output logic [31:0]         stat_lookups,
    output logic [31:0]         stat_mispred
`endif
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;
    localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
    // Only the top bit set: the weakest counter value that still predicts taken.
    localparam logic [CTR_W-1:0] CTR_WEAK = CTR_MAX ^ (CTR_MAX >> 1);

    logic             valid_q  [ENTRIES];
    logic             valid_d  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [TAG_W-1:0] tag_d    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [31:0]      target_d [ENTRIES];
    logic [CTR_W-1:0] ctr_q    [ENTRIES];
    logic [CTR_W-1:0] ctr_d    [ENTRIES];

    logic [IDX_W-1:0] f_idx_s;
    logic [TAG_W-1:0] f_tag_s;
    logic             f_hit_s;
    logic [CTR_W-1:0] f_ctr_s;
    logic             pred_taken_s;

    logic [IDX_W-1:0] u_idx_s;
    logic [TAG_W-1:0] u_tag_s;
    logic             u_hit_s;
    logic [CTR_W-1:0] u_ctr_s;
    logic             upd_en_s;
    logic             mispredict_s;

    // Byte offset within a word never participates in indexing or tagging.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.fetch_pc[1:0], bus.upd_pc[1:0]};

    // Zero-cycle lookup at the fetch PC; sees pre-update contents.
    always_comb begin
        f_idx_s      = bus.fetch_pc[IDX_W+1:2];
        f_tag_s      = bus.fetch_pc[31:IDX_W+2];
        f_hit_s      = valid_q[f_idx_s] && (tag_q[f_idx_s] == f_tag_s);
        f_ctr_s      = ctr_q[f_idx_s];
        pred_taken_s = f_hit_s && f_ctr_s[CTR_W-1];
    end

    assign bus.pred_taken  = pred_taken_s;
    assign bus.pred_target = pred_taken_s ? target_q[f_idx_s] : (bus.fetch_pc + 32'd4);

    // Resolution check: wrong direction, or taken to a different target.
    always_comb begin
        mispredict_s = bus.upd_valid &&
                       ((bus.upd_taken != bus.upd_pred_taken) ||
                        (bus.upd_taken && (bus.upd_target != bus.upd_pred_target)));
    end

    assign bus.mispredict = mispredict_s;
    assign bus.recover_pc = bus.upd_taken ? bus.upd_target : (bus.upd_pc + 32'd4);

    // Next-state of the table from the resolved instruction.
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        u_idx_s  = bus.upd_pc[IDX_W+1:2];
        u_tag_s  = bus.upd_pc[31:IDX_W+2];
        u_hit_s  = valid_q[u_idx_s] && (tag_q[u_idx_s] == u_tag_s);
        u_ctr_s  = ctr_q[u_idx_s];
        // An update racing a reset is dropped, including the unreset fields.
        upd_en_s = bus.upd_valid && !RST;
        if (upd_en_s) begin
            case ({u_hit_s, bus.upd_taken})
                2'b11: begin
                    ctr_d[u_idx_s]    = (u_ctr_s == CTR_MAX) ? u_ctr_s : (u_ctr_s + CTR_W'(1));
                    target_d[u_idx_s] = bus.upd_target;
                end
                2'b10: begin
                    ctr_d[u_idx_s] = (u_ctr_s == '0) ? u_ctr_s : (u_ctr_s - CTR_W'(1));
                end
                2'b01: begin
                    valid_d[u_idx_s]  = 1'b1;
                    tag_d[u_idx_s]    = u_tag_s;
                    target_d[u_idx_s] = bus.upd_target;
                    ctr_d[u_idx_s]    = CTR_WEAK;
                end
                default: begin
                    // Not-taken miss: nothing worth learning.
                    ctr_d[u_idx_s] = u_ctr_s;
                end
            endcase
        end else begin
            ctr_d[u_idx_s] = u_ctr_s;
        end
    end

    // Valid bits and counters: async clear so all history is lost at once.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= '0;
            end
        end else begin
            valid_q <= valid_d;
            ctr_q   <= ctr_d;
        end
    end

    // Tag and target storage; meaningless while the valid bit is clear.
    always_ff @(posedge CLK) begin
        tag_q    <= tag_d;
        target_q <= target_d;
    end

`ifdef BRANCH_PREDICTOR_STATS_EN
    logic [31:0] stat_lookups_q;
    logic [31:0] stat_lookups_d;
    logic [31:0] stat_mispred_q;
    logic [31:0] stat_mispred_d;

    // Saturating statistics: one lookup per unreset cycle, plus mispredicts.
    always_comb begin
        stat_lookups_d = (stat_lookups_q == 32'hFFFF_FFFF) ? stat_lookups_q
                                                           : (stat_lookups_q + 32'd1);
        if (mispredict_s && (stat_mispred_q != 32'hFFFF_FFFF)) begin
            stat_mispred_d = stat_mispred_q + 32'd1;
        end else begin
            stat_mispred_d = stat_mispred_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stat_lookups_q <= 32'd0;
            stat_mispred_q <= 32'd0;
        end else begin
            stat_lookups_q <= stat_lookups_d;
            stat_mispred_q <= stat_mispred_d;
        end
    end

    assign stat_lookups = stat_lookups_q;
    assign stat_mispred = stat_mispred_q;
`endif
endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (ENTRIES=16, CTR_W=2).
// Inputs change on the falling edge; combinational outputs are sampled 1 ns
// later and updates commit on the following rising edge.
module tb_branch_predictor;
    logic CLK;
    logic RST;
    int   n_checks;
    int   n_fail;

    branch_predictor_if bus();

`ifdef BRANCH_PREDICTOR_STATS_EN
    logic [31:0] stat_lookups;
    logic [31:0] stat_mispred;
`endif

    branch_predictor #(.ENTRIES(16), .CTR_W(2)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
`ifdef BRANCH_PREDICTOR_STATS_EN
        ,
        .stat_lookups (stat_lookups),
        .stat_mispred (stat_mispred)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] fpc, input logic v, input logic [31:0] pc,
                         input logic t, input logic [31:0] tgt,
                         input logic pt, input logic [31:0] ptg);
        bus.fetch_pc        = fpc;
        bus.upd_valid       = v;
        bus.upd_pc          = pc;
        bus.upd_taken       = t;
        bus.upd_target      = tgt;
        bus.upd_pred_taken  = pt;
        bus.upd_pred_target = ptg;
    endtask

    // New cycle: wait for falling edge, apply inputs, settle.
    task automatic cyc(input logic [31:0] fpc, input logic v, input logic [31:0] pc,
                       input logic t, input logic [31:0] tgt,
                       input logic pt, input logic [31:0] ptg);
        @(negedge CLK);
        drive(fpc, v, pc, t, tgt, pt, ptg);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        RST      = 1'b1;
        drive(32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        check("rst_pred_taken", {31'd0, bus.pred_taken}, 32'd0);
        check("rst_pred_target", bus.pred_target, 32'h44);
        check("rst_mispredict", {31'd0, bus.mispredict}, 32'd0);
        // Allocating update presented while RST is high must be discarded.
        drive(32'h40, 1'b1, 32'h140, 1'b1, 32'h900, 1'b0, 32'h144);
        @(negedge CLK);
        RST = 1'b0;
        drive(32'h140, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        check("rst_upd_discard_taken", {31'd0, bus.pred_taken}, 32'd0);
        check("rst_upd_discard_target", bus.pred_target, 32'h144);

        // First allocation; same-cycle lookup sees old contents.
        cyc(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
        check("alloc_same_cycle_pred", {31'd0, bus.pred_taken}, 32'd0);
        check("alloc_mispredict", {31'd0, bus.mispredict}, 32'd1);
        check("alloc_recover_pc", bus.recover_pc, 32'h100);
        cyc(32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("alloc_next_pred", {31'd0, bus.pred_taken}, 32'd1);
        check("alloc_next_target", bus.pred_target, 32'h100);

        // Counter training: 2 -> 1 -> 0.
        cyc(32'h40, 1'b1, 32'h40, 1'b0, 32'h100, 1'b1, 32'h100);
        check("nt_mispredict", {31'd0, bus.mispredict}, 32'd1);
        check("nt_recover_pc", bus.recover_pc, 32'h44);
        cyc(32'h40, 1'b1, 32'h40, 1'b0, 32'h100, 1'b0, 32'h44);
        check("ctr1_pred", {31'd0, bus.pred_taken}, 32'd0);
        check("nt_correct_mispredict", {31'd0, bus.mispredict}, 32'd0);
        // 0 -> 1 -> 2 -> 3 -> 3 (saturate high).
        cyc(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
        check("ctr0_pred", {31'd0, bus.pred_taken}, 32'd0);
        cyc(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
        check("ctr1b_pred", {31'd0, bus.pred_taken}, 32'd0);
        cyc(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
        check("ctr2_pred", {31'd0, bus.pred_taken}, 32'd1);
        cyc(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
        check("ctr3_pred", {31'd0, bus.pred_taken}, 32'd1);
        check("taken_correct_mispredict", {31'd0, bus.mispredict}, 32'd0);
        // Fourth taken kept ctr at 3: now 3 -> 2 -> 1 -> 0 -> 0 (saturate low).
        cyc(32'h40, 1'b1, 32'h40, 1'b0, 32'h100, 1'b1, 32'h100);
        check("sat_hi_pred", {31'd0, bus.pred_taken}, 32'd1);
        cyc(32'h40, 1'b1, 32'h40, 1'b0, 32'h100, 1'b1, 32'h100);
        check("sat_hi_ctr2_pred", {31'd0, bus.pred_taken}, 32'd1);
        cyc(32'h40, 1'b1, 32'h40, 1'b0, 32'h100, 1'b0, 32'h44);
        check("sat_hi_ctr1_pred", {31'd0, bus.pred_taken}, 32'd0);
        cyc(32'h40, 1'b1, 32'h40, 1'b0, 32'h100, 1'b0, 32'h44);
        cyc(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
        check("sat_lo_pred", {31'd0, bus.pred_taken}, 32'd0);
        // ctr 1 -> 2 with a new target.
        cyc(32'h40, 1'b1, 32'h40, 1'b1, 32'h200, 1'b0, 32'h44);
        check("sat_lo_ctr1_pred", {31'd0, bus.pred_taken}, 32'd0);
        cyc(32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("retarget_pred", {31'd0, bus.pred_taken}, 32'd1);
        check("retarget_target", bus.pred_target, 32'h200);

        // Right direction, wrong target.
        cyc(32'h40, 1'b1, 32'h40, 1'b1, 32'h200, 1'b1, 32'h100);
        check("tgt_mispredict", {31'd0, bus.mispredict}, 32'd1);
        check("tgt_recover_pc", bus.recover_pc, 32'h200);
        cyc(32'h40, 1'b1, 32'h40, 1'b1, 32'h200, 1'b1, 32'h200);
        check("tgt_match_mispredict", {31'd0, bus.mispredict}, 32'd0);

        // Alias: 0x80 shares index 0 with 0x40 and evicts it.
        cyc(32'h40, 1'b1, 32'h80, 1'b1, 32'h300, 1'b0, 32'h84);
        check("alias_pre_pred", {31'd0, bus.pred_taken}, 32'd1);
        cyc(32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("alias_old_pred", {31'd0, bus.pred_taken}, 32'd0);
        check("alias_old_target", bus.pred_target, 32'h44);
        cyc(32'h80, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("alias_new_pred", {31'd0, bus.pred_taken}, 32'd1);
        check("alias_new_target", bus.pred_target, 32'h300);

        // Not-taken miss at the aliased index changes nothing (0x80 stays at ctr 2).
        cyc(32'h80, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h44);
        check("ntmiss_mispredict", {31'd0, bus.mispredict}, 32'd0);
        cyc(32'h80, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("ntmiss_keep_pred", {31'd0, bus.pred_taken}, 32'd1);

        // upd_valid=0 forces mispredict low and trains nothing.
        cyc(32'h80, 1'b0, 32'hC4, 1'b1, 32'h500, 1'b0, 32'hC8);
        check("novalid_mispredict", {31'd0, bus.mispredict}, 32'd0);
        cyc(32'hC4, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("novalid_no_alloc", bus.pred_target, 32'hC8);
        cyc(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("pc_wrap_target", bus.pred_target, 32'h0);

        // Reset pulse between edges wipes history immediately.
        cyc(32'h80, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("pre_pulse_pred", {31'd0, bus.pred_taken}, 32'd1);
        #1 RST = 1'b1;
        #1;
        check("pulse_pred", {31'd0, bus.pred_taken}, 32'd0);
        check("pulse_target", bus.pred_target, 32'h84);
        #1 RST = 1'b0;
        cyc(32'h80, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("post_pulse_pred", {31'd0, bus.pred_taken}, 32'd0);

`ifdef BRANCH_PREDICTOR_STATS_EN
        // Ten unreset cycles, mispredicting in cycles 1, 4 and 7.
        @(negedge CLK);
        RST = 1'b1;
        drive(32'h400, 1'b0, 32'h400, 1'b1, 32'h600, 1'b0, 32'h404);
        #1 RST = 1'b0;
        for (int k = 1; k < 10; k++) begin
            cyc(32'h400, (k == 1) || (k == 4) || (k == 7), 32'h400, 1'b1, 32'h600, 1'b0, 32'h404);
        end
        cyc(32'h400, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("stat_lookups", stat_lookups, 32'd10);
        check("stat_mispred", stat_mispred, 32'd3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
